// File: rtl/blinkdecode.sv
`default_nettype none
// ============================================================================
// Module   : blinkdecode
// Purpose  : Recovers speed, pattern phase and link health from the observed
//            4-bit bounce-pattern LED bus of the blink-speed block.
// Revision : 1.0 - initial release
// ============================================================================
module blinkdecode #(
  parameter int W = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] LED,
  output logic [1:0] SPEED,
  output logic       VALID,
  output logic [2:0] PHASE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_MEASURE = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [W+1:0] C_ONE   = (W+2)'(1);
  localparam logic [W+1:0] C_P0    = C_ONE << W;
  localparam logic [W+1:0] C_P1    = C_ONE << (W - 1);
  localparam logic [W+1:0] C_P2    = C_ONE << (W - 2);
  localparam logic [W+1:0] C_P3    = C_ONE << (W - 3);
  localparam logic [W+1:0] C_STALL = C_P0 + C_ONE;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_led_q;
  logic [W+1:0] r_ivl;
  logic [1:0]   r_cand, w_cand_nxt;
  logic [1:0]   r_speed, w_speed_nxt;
  logic         r_valid, w_valid_nxt;
  logic [2:0]   r_phase, w_phase_nxt;
  logic         r_err, w_err_nxt;

  logic         w_change;
  logic         w_stall;
  logic         w_code_ok;
  logic         w_step_ok;
  logic [2:0]   w_step_phase;
  logic         w_cls_ok;
  logic [1:0]   w_cls;

  assign w_change = (LED != r_led_q);
  assign w_stall  = (r_ivl == C_STALL);

  always_comb begin
    w_code_ok = 1'b0;
    case (LED)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_code_ok = 1'b1;
      default:                            w_code_ok = 1'b0;
    endcase
  end

  // Bounce order 0001-0010-0100-1000-0100-0010; phase names the step just taken
  always_comb begin
    w_step_ok    = 1'b1;
    w_step_phase = 3'd0;
    case ({r_led_q, LED})
      8'b0001_0010: w_step_phase = 3'd1;
      8'b0010_0100: w_step_phase = 3'd2;
      8'b0100_1000: w_step_phase = 3'd3;
      8'b1000_0100: w_step_phase = 3'd4;
      8'b0100_0010: w_step_phase = 3'd5;
      8'b0010_0001: w_step_phase = 3'd0;
      default:      w_step_ok    = 1'b0;
    endcase
  end

  always_comb begin
    w_cls_ok = 1'b1;
    w_cls    = 2'd0;
    if (r_ivl == C_P0)      w_cls = 2'd0;
    else if (r_ivl == C_P1) w_cls = 2'd1;
    else if (r_ivl == C_P2) w_cls = 2'd2;
    else if (r_ivl == C_P3) w_cls = 2'd3;
    else                    w_cls_ok = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_led_q <= 4'b0000;
      r_ivl   <= '0;
    end else begin
      r_led_q <= LED;
      if (w_change)
        r_ivl <= C_ONE;
      else if (!w_stall)
        r_ivl <= r_ivl + C_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_HUNT;
      r_cand  <= 2'd0;
      r_speed <= 2'd0;
      r_valid <= 1'b0;
      r_phase <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_speed <= w_speed_nxt;
      r_valid <= w_valid_nxt;
      r_phase <= w_phase_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_speed_nxt = r_speed;
    w_valid_nxt = r_valid;
    w_phase_nxt = r_phase;
    w_err_nxt   = 1'b0;
    if (w_change) begin
      if (r_state == S_HUNT) begin
        if (w_code_ok) w_state_nxt = S_MEASURE;
        else           w_err_nxt   = 1'b1;
      end else if (!w_code_ok || !w_step_ok) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = S_HUNT;
        w_valid_nxt = 1'b0;
      end else begin
        w_phase_nxt = w_step_phase;
        case (r_state)
          S_MEASURE: begin
            if (w_cls_ok) begin
              w_state_nxt = S_CONFIRM;
              w_cand_nxt  = w_cls;
            end
          end
          S_CONFIRM: begin
            if (!w_cls_ok) begin
              w_state_nxt = S_MEASURE;
            end else if (w_cls == r_cand) begin
              w_state_nxt = S_LOCKED;
              w_speed_nxt = r_cand;
              w_valid_nxt = 1'b1;
            end else begin
              w_cand_nxt  = w_cls;
            end
          end
          S_LOCKED: begin
            if (!w_cls_ok) begin
              w_state_nxt = S_MEASURE;
              w_valid_nxt = 1'b0;
            end else if (w_cls != r_speed) begin
              w_state_nxt = S_CONFIRM;
              w_cand_nxt  = w_cls;
              w_valid_nxt = 1'b0;
            end
          end
          default: w_state_nxt = S_HUNT;
        endcase
      end
    end else if (r_state == S_LOCKED && w_stall) begin
      // Saturated interval with no edge: the blinker has stopped
      w_state_nxt = S_MEASURE;
      w_valid_nxt = 1'b0;
    end
  end

  assign SPEED = r_speed;
  assign VALID = r_valid;
  assign PHASE = r_phase;
  assign ERR   = r_err;

endmodule
`default_nettype wire

// File: doc/blinkdecode.md
# blinkdecode

Monitor that observes the 4-bit bounce-pattern LED bus produced by the blink-speed block and recovers the current speed setting, pattern phase and link health. It is the receiving end of the LED pattern interface: it sits beside the blinker in the same clock domain and feeds the self-check / status logic. It also flags illegal codes and out-of-sequence steps.

## Interface
- W, default 25, base period exponent. Speed s step period is exactly 2^(W-s) cycles. Legal range 4..25.
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- LED  input  4  observed pattern bus, same clock domain as CLK, no synchronizer
- SPEED  output  2  last locked speed 0..3; holds its value while unlocked
- VALID  output  1  high while locked to a stable period
- PHASE  output  3  pattern phase 0..5 of the current LED code
- ERR  output  1  one-cycle pulse on an illegal code or an illegal step

## Operation
- Legal codes: 0001, 0010, 0100, 1000. Anything else is illegal.
- Legal steps and the resulting phase:
  - 0001→0010 = 1
  - 0010→0100 = 2
  - 0100→1000 = 3
  - 1000→0100 = 4
  - 0100→0010 = 5
  - 0010→0001 = 0
- All other code-to-code changes are illegal steps.
- led_q register: previous LED, reset 0000. A change is detected in any cycle where LED != led_q.
- Interval counter ivl: W+2 bits, reset 0.
  - Loads 1 in the cycle after a change.
  - Otherwise increments, saturating at 2^W+1.
  - At a detected change, ivl equals the step period in cycles.
- Classification at a change: ivl == 2^(W-s) gives class s. Any other value is unclassified. Matching is exact, with no tolerance.
- FSM states HUNT, MEASURE, CONFIRM, LOCKED; reset state is HUNT. The candidate register cand is 2 bits, reset 0.
- HUNT:
  - Change to a legal code → MEASURE; no step check, no ERR.
  - Change to an illegal code → ERR pulse, stay in HUNT.
- MEASURE, CONFIRM, LOCKED, on a change:
  - Illegal code or illegal step → ERR pulse, HUNT, VALID=0.
  - Otherwise PHASE is updated from the step table, then the state-specific rule below applies.
- MEASURE: class s → CONFIRM with cand=s. Unclassified → stay in MEASURE.
- CONFIRM:
  - Class == cand → LOCKED, SPEED=cand, VALID=1.
  - Class s != cand → stay in CONFIRM with cand=s.
  - Unclassified → MEASURE.
- LOCKED:
  - Class == SPEED → stay in LOCKED.
  - Class s != SPEED → CONFIRM with cand=s, VALID=0.
  - Unclassified → MEASURE, VALID=0.
- Stall: in LOCKED, ivl reaching 2^W+1 with no change → MEASURE, VALID=0.
- Priority rules:
  - RST beats everything.
  - A change beats stall in the same cycle; the interval is then unclassified.
- PHASE is meaningful only outside HUNT. It holds its last value in HUNT.

## Timing
- Reset values: SPEED=0, VALID=0, PHASE=0, ERR=0, state=HUNT, ivl=0, led_q=0000, cand=0.
- All outputs are registered. They reflect a change detected in cycle t at cycle t+1.
- ERR is high for exactly one cycle per offending change.
- Lock latency: VALID rises one cycle after the third legal change following HUNT (reference, measure, confirm).
- Blinker and decoder reset together at speed 0:
  - Cycle 0: 0001 vs led_q 0000 is the reference change.
  - Changes follow at cycles 2^W and 2·2^W.
  - VALID rises at cycle 2·2^W+1 with SPEED=0.
- A mid-stream speed change gives one irregular interval, because the blinker's divider is free-running. VALID drops, then re-locks after two matching intervals.
- RST mid-lock: all outputs are at reset values on the next cycle.

## Test plan
- W=6, drive the legal bounce with a 64-cycle step period from reset → VALID rises at cycle 129, SPEED=0, PHASE steps 1,2,3,4,5,0,..., ERR never asserted.
- W=6, locked at period 64, switch to a period-8 bounce with one irregular interval → VALID drops at that edge, then re-locks after two 8-cycle intervals with SPEED=3.
- W=6, locked, inject LED=0110 for one step → ERR pulses once, VALID=0, state HUNT, re-lock after three further legal changes.
- W=6, locked, jump 0001→0100 → ERR pulse, VALID=0; PHASE holds its last value.
- W=6, locked at SPEED=1 (period 32), freeze LED → VALID falls at the cycle ivl reaches 65 (plus one cycle for the registered output); SPEED stays 1.
- W=6, assert RST while locked at SPEED=2 → next cycle SPEED=0, VALID=0, PHASE=0, ERR=0.
